// File: rtl/bp_nonsynth_io_loader_mux.sv
// N-source I/O command mux for the nonsynth loaders.
// Tag FIFO of granted source IDs routes responses back in order.
module bp_nonsynth_io_loader_mux #(
  parameter int msg_width_p       = 64,
  parameter int num_src_p         = 2,
  parameter int max_outstanding_p = 4,
  parameter int rr_mode_p         = 0,
  localparam int tag_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1,
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1),
  localparam int ptr_w_lp =
    (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_src_p*msg_width_p-1:0]   src_cmd_i,
  input  logic [num_src_p-1:0]               src_cmd_v_i,
  output logic [num_src_p-1:0]               src_cmd_yumi_o,
  output logic [num_src_p*msg_width_p-1:0]   src_resp_o,
  output logic [num_src_p-1:0]               src_resp_v_o,
  input  logic [num_src_p-1:0]               src_resp_ready_i,
  output logic [msg_width_p-1:0]             io_cmd_o,
  output logic                               io_cmd_v_o,
  input  logic                               io_cmd_ready_i,
  input  logic [msg_width_p-1:0]             io_resp_i,
  input  logic                               io_resp_v_i,
  output logic                               io_resp_yumi_o,
  output logic [cnt_w_lp-1:0]                outstanding_o,
  output logic                               err_o
);

  logic [cnt_w_lp-1:0] count_r;
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [tag_w_lp-1:0] tag_mem_r [max_outstanding_p];
  logic [tag_w_lp-1:0] last_r;
  logic [tag_w_lp-1:0] grant;
  logic [tag_w_lp-1:0] head;
  logic [num_src_p-1:0] eligible;
  logic err_r;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic found;
  logic head_ready;
  int   rr_idx;

  // Fullness uses the registered count: a same-cycle pop frees nothing.
  assign full     = (count_r == cnt_w_lp'(max_outstanding_p));
  assign empty    = (count_r == '0);
  assign eligible = src_cmd_v_i & {num_src_p{~full}};
  assign head     = tag_mem_r[rd_ptr_r];

  assign io_cmd_v_o     = |eligible;
  assign push           = io_cmd_v_o & io_cmd_ready_i;
  assign io_resp_yumi_o = io_resp_v_i & ~empty & head_ready;
  assign pop            = io_resp_yumi_o;
  assign src_resp_o     = {num_src_p{io_resp_i}};
  assign outstanding_o  = count_r;
  assign err_o          = err_r;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    rr_idx = 0;
    if (rr_mode_p != 0) begin
      for (int k = 0; k < num_src_p; k++) begin
        rr_idx = (int'(last_r) + 1 + k) % num_src_p;
        if (!found && eligible[rr_idx]) begin
          grant = tag_w_lp'(rr_idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = num_src_p - 1; i >= 0; i--) begin
        if (eligible[i]) grant = tag_w_lp'(i);
      end
    end
  end

  always_comb begin
    io_cmd_o       = '0;
    src_cmd_yumi_o = '0;
    src_resp_v_o   = '0;
    head_ready     = 1'b0;
    for (int i = 0; i < num_src_p; i++) begin
      if (io_cmd_v_o && grant == tag_w_lp'(i)) begin
        io_cmd_o          = src_cmd_i[i*msg_width_p +: msg_width_p];
        src_cmd_yumi_o[i] = io_cmd_ready_i;
      end
      if (head == tag_w_lp'(i)) begin
        src_resp_v_o[i] = io_resp_v_i & ~empty;
        head_ready      = src_resp_ready_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem_r[wr_ptr_r] <= grant;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      last_r   <= tag_w_lp'(num_src_p - 1);
      err_r    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_outstanding_p - 1))
                  ? '0 : wr_ptr_r + 1'b1;
        last_r   <= grant;
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_outstanding_p - 1))
                  ? '0 : rd_ptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      // An orphan response is left unconsumed and flagged.
      if (io_resp_v_i && empty) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_io_loader_mux.sv
// Bench for bp_nonsynth_io_loader_mux: fixed and round-robin instances
// share stimulus; a tag queue per instance predicts response routing.
module tb_bp_nonsynth_io_loader_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_cmd;
  logic [1:0]  src_cmd_v;
  logic [1:0]  src_resp_ready;
  logic        io_cmd_ready;
  logic [15:0] io_resp;
  logic        io_resp_v;

  logic [1:0]  f_yumi, r_yumi;
  logic [31:0] f_resp, r_resp;
  logic [1:0]  f_resp_v, r_resp_v;
  logic [15:0] f_cmd, r_cmd;
  logic        f_cmd_v, r_cmd_v;
  logic        f_resp_yumi, r_resp_yumi;
  logic [2:0]  f_out, r_out;
  logic        f_err, r_err;

  int n_cmp = 0;
  int n_bad = 0;

  int   q_r[$];
  int   q_f[$];
  int   m_last;
  logic m_err_r, m_err_f;

  logic        e_r_v, e_f_v;
  logic [1:0]  e_r_yumi, e_f_yumi;
  logic [15:0] e_r_cmd, e_f_cmd;
  logic [1:0]  e_r_resp_v, e_f_resp_v;
  logic        e_r_resp_yumi, e_f_resp_yumi;
  int          e_r_out, e_f_out;
  logic        e_r_err;

  always #5 clk = ~clk;

  bp_nonsynth_io_loader_mux #(
    .msg_width_p(16), .num_src_p(2),
    .max_outstanding_p(4), .rr_mode_p(0)
  ) dut_f (
    .clk_i(clk), .reset_i(reset),
    .src_cmd_i(src_cmd), .src_cmd_v_i(src_cmd_v),
    .src_cmd_yumi_o(f_yumi),
    .src_resp_o(f_resp), .src_resp_v_o(f_resp_v),
    .src_resp_ready_i(src_resp_ready),
    .io_cmd_o(f_cmd), .io_cmd_v_o(f_cmd_v),
    .io_cmd_ready_i(io_cmd_ready),
    .io_resp_i(io_resp), .io_resp_v_i(io_resp_v),
    .io_resp_yumi_o(f_resp_yumi),
    .outstanding_o(f_out), .err_o(f_err)
  );

  bp_nonsynth_io_loader_mux #(
    .msg_width_p(16), .num_src_p(2),
    .max_outstanding_p(4), .rr_mode_p(1)
  ) dut_r (
    .clk_i(clk), .reset_i(reset),
    .src_cmd_i(src_cmd), .src_cmd_v_i(src_cmd_v),
    .src_cmd_yumi_o(r_yumi),
    .src_resp_o(r_resp), .src_resp_v_o(r_resp_v),
    .src_resp_ready_i(src_resp_ready),
    .io_cmd_o(r_cmd), .io_cmd_v_o(r_cmd_v),
    .io_cmd_ready_i(io_cmd_ready),
    .io_resp_i(io_resp), .io_resp_v_i(io_resp_v),
    .io_resp_yumi_o(r_resp_yumi),
    .outstanding_o(r_out), .err_o(r_err)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    src_cmd = '0; src_cmd_v = '0; src_resp_ready = '0;
    io_cmd_ready = 1'b0; io_resp = '0; io_resp_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q_r.delete(); q_f.delete();
    m_last = 1; m_err_r = 1'b0; m_err_f = 1'b0;
    #3;
  endtask

  // Drive one cycle and predict both instances from the bench model.
  task automatic drive(input logic [1:0] v, input logic rv,
                       input logic [1:0] rrdy, input logic rdy);
    int g;
    @(posedge clk); #1;
    src_cmd_v = v; io_resp_v = rv;
    src_resp_ready = rrdy; io_cmd_ready = rdy;
    src_cmd = {16'($urandom), 16'($urandom)};
    io_resp = 16'($urandom);
    e_r_out = q_r.size(); e_r_err = m_err_r;
    e_r_v = (v != 2'b00) && (q_r.size() < 4);
    g = -1;
    if (e_r_v)
      for (int k = 0; k < 2; k++)
        if (g < 0 && v[(m_last + 1 + k) % 2]) g = (m_last + 1 + k) % 2;
    e_r_yumi = (e_r_v && rdy) ? 2'(1 << g) : 2'b00;
    e_r_cmd  = e_r_v ? src_cmd[g*16 +: 16] : 16'h0;
    e_r_resp_v = 2'b00; e_r_resp_yumi = 1'b0;
    if (rv && q_r.size() > 0) begin
      e_r_resp_v = 2'(1 << q_r[0]);
      e_r_resp_yumi = rrdy[q_r[0]];
    end
    if (rv && q_r.size() == 0) m_err_r = 1'b1;
    if (e_r_resp_yumi) void'(q_r.pop_front());
    if (e_r_v && rdy) begin q_r.push_back(g); m_last = g; end
    e_f_out = q_f.size();
    e_f_v = (v != 2'b00) && (q_f.size() < 4);
    g = v[0] ? 0 : 1;
    e_f_yumi = (e_f_v && rdy) ? 2'(1 << g) : 2'b00;
    e_f_cmd  = e_f_v ? src_cmd[g*16 +: 16] : 16'h0;
    e_f_resp_v = 2'b00; e_f_resp_yumi = 1'b0;
    if (rv && q_f.size() > 0) begin
      e_f_resp_v = 2'(1 << q_f[0]);
      e_f_resp_yumi = rrdy[q_f[0]];
    end
    if (rv && q_f.size() == 0) m_err_f = 1'b1;
    if (e_f_resp_yumi) void'(q_f.pop_front());
    if (e_f_v && rdy) q_f.push_back(g);
    #3;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (r_cmd_v !== 1'b0 || f_cmd_v !== 1'b0) begin
      n_bad++; $display("FAIL reset_cmd_v got %b/%b want 0/0", r_cmd_v, f_cmd_v);
    end
    if (r_yumi !== 2'b00) begin
      n_bad++; $display("FAIL reset_yumi got %b want 00", r_yumi);
    end
    if (r_resp_v !== 2'b00 || r_resp_yumi !== 1'b0) begin
      n_bad++; $display("FAIL reset_resp got %b/%b want 00/0", r_resp_v, r_resp_yumi);
    end
    if (r_out !== 3'd0) begin
      n_bad++; $display("FAIL reset_out got %0d want 0", r_out);
    end
    if (f_out !== 3'd0) begin
      n_bad++; $display("FAIL reset_fout got %0d want 0", f_out);
    end
    if (r_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err got %b want 0", r_err);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, i == 6, 2'b11, 1'b1);
      n_cmp += 5;
      if (f_yumi !== e_f_yumi) begin
        n_bad++; $display("FAIL fix_yumi[%0d] got %b want %b", i, f_yumi, e_f_yumi);
      end
      if (f_cmd_v !== e_f_v) begin
        n_bad++; $display("FAIL fix_cmd_v[%0d] got %b want %b", i, f_cmd_v, e_f_v);
      end
      if (f_cmd !== e_f_cmd) begin
        n_bad++; $display("FAIL fix_cmd[%0d] got %h want %h", i, f_cmd, e_f_cmd);
      end
      if (f_out !== 3'(e_f_out)) begin
        n_bad++; $display("FAIL fix_out[%0d] got %0d want %0d", i, f_out, e_f_out);
      end
      if (f_resp_v !== e_f_resp_v || f_resp_yumi !== e_f_resp_yumi) begin
        n_bad++;
        $display("FAIL fix_resp[%0d] got %b/%b want %b/%b",
                 i, f_resp_v, f_resp_yumi, e_f_resp_v, e_f_resp_yumi);
      end
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, i > 0, 2'b11, 1'b1);
      n_cmp += 5;
      if (r_yumi !== e_r_yumi || r_yumi !== 2'(1 << (i % 2))) begin
        n_bad++; $display("FAIL rr_yumi[%0d] got %b want %b", i, r_yumi, e_r_yumi);
      end
      if (r_cmd !== e_r_cmd) begin
        n_bad++; $display("FAIL rr_cmd[%0d] got %h want %h", i, r_cmd, e_r_cmd);
      end
      if (r_resp_v !== e_r_resp_v || r_resp_yumi !== e_r_resp_yumi) begin
        n_bad++;
        $display("FAIL rr_resp[%0d] got %b/%b want %b/%b",
                 i, r_resp_v, r_resp_yumi, e_r_resp_v, e_r_resp_yumi);
      end
      if (r_out !== 3'(e_r_out)) begin
        n_bad++; $display("FAIL rr_out[%0d] got %0d want %0d", i, r_out, e_r_out);
      end
      if (r_resp !== {io_resp, io_resp}) begin
        n_bad++; $display("FAIL rr_resp_data[%0d] got %h want %h", i, r_resp, {io_resp, io_resp});
      end
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    repeat (4) drive(2'b01, 1'b0, 2'b11, 1'b1);
    drive(2'b01, 1'b1, 2'b11, 1'b1);
    n_cmp += 3;
    if (r_out !== 3'd4) begin
      n_bad++; $display("FAIL full_out got %0d want 4", r_out);
    end
    if (r_cmd_v !== 1'b0 || r_yumi !== 2'b00) begin
      n_bad++; $display("FAIL full_push_blocked got %b/%b want 0/00", r_cmd_v, r_yumi);
    end
    if (r_resp_yumi !== 1'b1 || r_resp_v !== 2'b01) begin
      n_bad++; $display("FAIL full_pop got %b/%b want 1/01", r_resp_yumi, r_resp_v);
    end
    drive(2'b01, 1'b0, 2'b11, 1'b1);
    n_cmp += 2;
    if (r_out !== 3'd3) begin
      n_bad++; $display("FAIL full_after_pop got %0d want 3", r_out);
    end
    if (r_yumi !== 2'b01) begin
      n_bad++; $display("FAIL full_retry_yumi got %b want 01", r_yumi);
    end
    drive(2'b00, 1'b0, 2'b11, 1'b1);
    n_cmp++;
    if (r_out !== 3'd4) begin
      n_bad++; $display("FAIL full_refill got %0d want 4", r_out);
    end
  endtask

  task automatic test_head_ready();
    do_reset();
    drive(2'b11, 1'b0, 2'b11, 1'b1);
    drive(2'b11, 1'b0, 2'b11, 1'b1);
    drive(2'b00, 1'b1, 2'b11, 1'b1);
    n_cmp++;
    if (r_resp_v !== 2'b01 || r_resp_yumi !== 1'b1) begin
      n_bad++; $display("FAIL head0_pop got %b/%b want 01/1", r_resp_v, r_resp_yumi);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b1, 2'b01, 1'b1);
      n_cmp += 2;
      if (r_resp_v !== 2'b10 || r_resp_yumi !== 1'b0) begin
        n_bad++; $display("FAIL head1_hold[%0d] got %b/%b want 10/0", i, r_resp_v, r_resp_yumi);
      end
      if (r_out !== 3'd1) begin
        n_bad++; $display("FAIL head1_out[%0d] got %0d want 1", i, r_out);
      end
    end
    drive(2'b00, 1'b1, 2'b11, 1'b1);
    n_cmp++;
    if (r_resp_v !== 2'b10 || r_resp_yumi !== 1'b1) begin
      n_bad++; $display("FAIL head1_release got %b/%b want 10/1", r_resp_v, r_resp_yumi);
    end
    drive(2'b00, 1'b0, 2'b11, 1'b1);
    n_cmp++;
    if (r_out !== 3'd0) begin
      n_bad++; $display("FAIL head1_drained got %0d want 0", r_out);
    end
  endtask

  task automatic test_err_and_reset();
    do_reset();
    drive(2'b00, 1'b1, 2'b11, 1'b1);
    n_cmp++;
    if (r_resp_yumi !== 1'b0 || r_resp_v !== 2'b00 || r_err !== 1'b0) begin
      n_bad++;
      $display("FAIL orphan_resp got %b/%b/%b want 0/00/0", r_resp_yumi, r_resp_v, r_err);
    end
    drive(2'b00, 1'b0, 2'b11, 1'b1);
    n_cmp++;
    if (r_err !== 1'b1) begin
      n_bad++; $display("FAIL err_set got %b want 1", r_err);
    end
    drive(2'b11, 1'b0, 2'b11, 1'b1);
    drive(2'b11, 1'b0, 2'b11, 1'b1);
    drive(2'b00, 1'b0, 2'b11, 1'b1);
    n_cmp += 2;
    if (r_out !== 3'd2) begin
      n_bad++; $display("FAIL pre_reset_out got %0d want 2", r_out);
    end
    if (r_err !== e_r_err || r_err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky got %b want 1", r_err);
    end
    do_reset();
    n_cmp += 2;
    if (r_out !== 3'd0) begin
      n_bad++; $display("FAIL mid_reset_out got %0d want 0", r_out);
    end
    if (r_err !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_err got %b want 0", r_err);
    end
    drive(2'b11, 1'b0, 2'b11, 1'b1);
    n_cmp++;
    if (r_yumi !== 2'b01) begin
      n_bad++; $display("FAIL rr_first_after_reset got %b want 01", r_yumi);
    end
  endtask

  initial begin
    reset = 1'b1;
    src_cmd = '0; src_cmd_v = '0; src_resp_ready = '0;
    io_cmd_ready = 1'b0; io_resp = '0; io_resp_v = 1'b0;
    test_reset();
    test_fixed_priority();
    test_rr_order();
    test_full_pop_push();
    test_head_ready();
    test_err_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_io_loader_mux.md
# bp_nonsynth_io_loader_mux

Parametrised N-source I/O command multiplexer for the nonsynth loader path. It generalises the fixed two-way NBF/config mutex steering into an arbiter over `num_src_p` `bp_cce_io_msg_s` command sources, selectable as fixed-priority or round-robin. It keeps an in-order tag FIFO of granted source IDs so that each response is routed back to the source that issued the command. It sits between the testbench loaders (NBF, CCE cfg, future debug loaders) and `bp_me_cce_to_io_link_bidir`.

## Interface
Parameters:
- `bp_params_p`, `BP_CFG_FLOWVAR`: processor config; provides `bp_cce_io_msg_s` width.
- `num_src_p`, 2: number of command sources; must be ≥1.
- `max_outstanding_p`, 4: tag FIFO depth, i.e. the maximum number of commands in flight without a response; must be ≥1.
- `rr_mode_p`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `src_cmd_i`  in  `num_src_p`×msg  per-source command.
- `src_cmd_v_i`  in  `num_src_p`  per-source valid; must be held until yumi.
- `src_cmd_yumi_o`  out  `num_src_p`  one-hot acceptance.
- `src_resp_o`  out  `num_src_p`×msg  response, broadcast to all sources.
- `src_resp_v_o`  out  `num_src_p`  one-hot response valid.
- `src_resp_ready_i`  in  `num_src_p`  per-source response ready.
- `io_cmd_o`  out  msg  muxed command.
- `io_cmd_v_o`  out  1  command valid.
- `io_cmd_ready_i`  in  1  downstream ready.
- `io_resp_i`  in  msg  downstream response.
- `io_resp_v_i`  in  1  response valid.
- `io_resp_yumi_o`  out  1  response consumed.
- `outstanding_o`  out  `clog2(max_outstanding_p+1)`  FIFO occupancy.
- `err_o`  out  1  sticky: a response arrived with no command outstanding.

## Operation
- Eligibility: source i is eligible when `src_cmd_v_i[i]` is high and the FIFO is not full. Fullness is taken from the registered count; a pop in the same cycle does not free a slot for a push.
- Grant in fixed mode: the lowest-index eligible source.
- Grant in round-robin mode: search starts at `(last_r+1) mod num_src_p`. `last_r` resets to `num_src_p-1`, so source 0 is served first after reset. `last_r` updates only on a transfer, to the granted index.
- `io_cmd_v_o` = any source eligible. `io_cmd_o` = the granted source's message; it is don't-care, driven as '0, when `io_cmd_v_o` is low.
- Transfer occurs when `io_cmd_v_o & io_cmd_ready_i`. On transfer:
  - `src_cmd_yumi_o[grant]` = 1;
  - the grant index is pushed into the tag FIFO.
- Response routing (head = FIFO head index):
  - `src_resp_o` = `io_resp_i` for all sources;
  - `src_resp_v_o[head]` = `io_resp_v_i & ~empty`; all other bits 0;
  - `io_resp_yumi_o` = `io_resp_v_i & ~empty & src_resp_ready_i[head]`;
  - pop on `io_resp_yumi_o`.
- Response with FIFO empty: not consumed (yumi = 0), and `err_o` is set. `err_o` clears only on reset.
- Simultaneous push and pop: both happen and the count is unchanged. When full, the push is blocked even if a pop occurs that cycle.
- Occupancy: `outstanding_o` = count register; it increments on push-only and decrements on pop-only.
- Reset mid-operation: FIFO pointers, count, `last_r` and `err_o` clear. In-flight responses are orphaned; the bench must re-reset downstream.
- `num_src_p`=1: the arbiter degenerates to a pass-through plus FIFO. Tag width is `max(1, clog2(num_src_p))`.

## Timing
- Command path is combinational (0-cycle) from `src_cmd_v_i`/`io_cmd_ready_i` to `io_cmd_v_o`/`src_cmd_yumi_o`. There is no combinational path from `io_cmd_ready_i` to `io_cmd_v_o`.
- Response path is combinational (0-cycle) from `io_resp_v_i` to `src_resp_v_o`/`io_resp_yumi_o`.
- FIFO, count, `last_r` and `err_o` update on the clock edge following the event.
- Reset values: all `*_v_o`/`*_yumi_o` = 0, `outstanding_o` = 0, `err_o` = 0.
- Throughput: one command and one response per cycle.

## Test plan
- Fixed mode, src0 and src1 valid continuously, ready = 1 → grants go 0,0,0,0 (src1 starved); `outstanding_o` reaches 4, then `io_cmd_v_o` = 0 until a response pops.
- `rr_mode_p`=1, both sources valid, ready = 1, responses returned promptly → grant order is 0,1,0,1,…; each response appears on the `src_resp_v_o` bit matching its issue order.
- Fill to 4 outstanding, then in the same cycle a new valid command and a response → the pop occurs, the push is blocked, and the count goes 4→3; the push is accepted on the next cycle.
- Response at head = 1 with `src_resp_ready_i[1]` = 0 for 3 cycles → `io_resp_yumi_o` stays 0 and the FIFO stays unchanged; when ready rises, it pops in the same cycle.
- `io_resp_v_i` = 1 with 0 outstanding → `io_resp_yumi_o` = 0 and `err_o` = 1 from the next cycle, staying high until reset.
- Assert `reset_i` with 2 outstanding → next cycle `outstanding_o` = 0, `err_o` = 0, and the first round-robin grant is source 0.
